// File: rtl/sync_xfer_tx_if.sv
// Handshake bundle for sync_xfer_tx: producer valid/ready side, far-domain
// req/ack/data side, and the status outputs.
interface sync_xfer_tx_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         xfer_req;
    logic [W-1:0] xfer_data;
    logic         xfer_ack;
    logic         busy;
    logic         done;

    // master: the transmitter block itself
    modport master (
        input  in_valid, in_data, xfer_ack,
        output in_ready, xfer_req, xfer_data, busy, done
    );

    // slave: producer plus far-domain responder
    modport slave (
        output in_valid, in_data, xfer_ack,
        input  in_ready, xfer_req, xfer_data, busy, done
    );
endinterface

// File: rtl/sync_xfer_tx.sv
// sync_xfer_tx: source end of a four-phase req/ack clock-domain crossing.
// One word in flight on xfer_data (frozen from launch to next launch) plus a
// one-entry pending buffer so the producer can queue the following word.
module sync_xfer_tx #(
    parameter int W     = 32,
    parameter int NSYNC = 2
) (
    input  logic           in_clk,
    input  logic           reset_n,
    sync_xfer_tx_if.master bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         req_q, req_d;
    logic [W-1:0] data_q, data_d;
    logic         pend_valid_q, pend_valid_d;
    logic [W-1:0] pend_data_q, pend_data_d;
    logic         done_q, done_d;

    (* ASYNC_REG = "TRUE" *) logic [NSYNC-1:0] sync_q;
    logic [NSYNC-1:0] sync_d;

    logic ack_s;
    logic in_fire;
    logic have_word;
    logic launch;

    // Shift the raw ack level into the synchronizer; only sync_q[0] sees xfer_ack
    always_comb sync_d = {sync_q[NSYNC-2:0], bus.xfer_ack};

    assign ack_s     = sync_q[NSYNC-1];
    assign in_fire   = bus.in_valid & ~pend_valid_q;
    assign have_word = pend_valid_q | in_fire;
    // A launch needs the far side quiet (ack low) and either an idle channel
    // or a RELEASE that is completing on this very edge.
    assign launch    = have_word & ~ack_s & ((state_q == IDLE) | (state_q == RELEASE));

    // Handshake FSM, launch datapath and pending-buffer management
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        data_d       = data_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) state_d = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    state_d = RELEASE;
                    req_d   = 1'b0;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = have_word ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (launch) begin
            req_d  = 1'b1;
            data_d = pend_valid_q ? pend_data_q : bus.in_data;
            if (pend_valid_q) pend_valid_d = 1'b0;
        end

        // in_fire implies pend is empty, so pend never sources a launch on
        // the same edge a new word is accepted; the new word parks in pend
        // whenever it is not launched directly.
        if (in_fire && !launch) begin
            pend_valid_d = 1'b1;
            pend_data_d  = bus.in_data;
        end
    end

    // State registers; reset drops req at once and discards any pending word
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            data_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            done_q       <= 1'b0;
            sync_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            data_q       <= data_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            done_q       <= done_d;
            sync_q       <= sync_d;
        end
    end

    assign bus.in_ready  = ~pend_valid_q;
    assign bus.xfer_req  = req_q;
    assign bus.xfer_data = data_q;
    assign bus.busy      = (state_q != IDLE) | pend_valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sync_xfer_tx.sv
// Bench for sync_xfer_tx: producer driver pushes every accepted word onto a
// scoreboard queue; a far-side responder process acks with programmable
// delay; a monitor pops the queue on every req rise and checks data, order,
// latencies, stability, ready and busy against a transaction-level model.
module tb_sync_xfer_tx;
    localparam int W     = 32;
    localparam int NSYNC = 2;

    logic in_clk  = 1'b0;
    logic reset_n = 1'b0;

    sync_xfer_tx_if #(.W(W)) bus ();

    sync_xfer_tx #(.W(W), .NSYNC(NSYNC)) dut (
        .in_clk (in_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [W-1:0] data;
        int           fe;    // edge on which the word was accepted
    } item_t;

    item_t exp_q[$];
    int checks = 0, failures = 0;
    int ecnt = 0;

    always @(posedge in_clk) ecnt <= ecnt + 1;

    function automatic void chk(bit ok, string name, longint act, longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // ---------------- far-side responder ----------------
    int   resp_force = 1;
    logic force_val  = 1'b0;
    int   dmin = 3, dmax = 3, cur_dly = 3, rcnt = 0;
    int   ack_rise_edge = -100, ack_fall_edge = -100, ack_fall_cnt = 0;

    task automatic set_ack(input logic v);
        bus.xfer_ack = v;
        if (v) ack_rise_edge = ecnt;
        else begin
            ack_fall_edge = ecnt;
            ack_fall_cnt++;
        end
    endtask

    initial begin
        bus.xfer_ack = 1'b0;
        forever begin
            @(negedge in_clk);
            if (resp_force != 0) begin
                if (bus.xfer_ack != force_val) set_ack(force_val);
                rcnt = 0;
            end else if (!reset_n || bus.xfer_ack == bus.xfer_req) begin
                rcnt = 0;
            end else if (rcnt >= cur_dly) begin
                set_ack(bus.xfer_req);
                rcnt    = 0;
                cur_dly = $urandom_range(dmax, dmin);
            end else begin
                rcnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    logic         prev_req = 1'b0;
    logic [W-1:0] prev_data = '0;
    int in_flight = 0, done_cnt = 0, relaunch_cnt = 0, rx_cnt = 0;

    always @(negedge in_clk) begin : mon
        int    waiting;
        bit    rise, fall, exp_rl, avail;
        item_t it;
        if (!reset_n) begin
            in_flight = 0;
        end else begin
            rise  = bus.xfer_req && !prev_req;
            fall  = !bus.xfer_req && prev_req;
            avail = (exp_q.size() > 0) && (exp_q[0].fe <= ecnt);
            if (bus.done) begin
                done_cnt++;
                chk(in_flight == 1, "done_spurious", in_flight, 1);
                chk(ecnt == ack_fall_edge + 1 + NSYNC, "done_latency",
                    ecnt - ack_fall_edge, 1 + NSYNC);
                exp_rl = avail;
                chk(rise == exp_rl, "relaunch_on_done", rise, exp_rl);
                if (rise) relaunch_cnt++;
                in_flight = 0;
            end
            if (rise) begin
                chk(avail, "launch_expected", bus.xfer_data, 1);
                if (avail) begin
                    it = exp_q.pop_front();
                    chk(bus.xfer_data == it.data, "launch_data", bus.xfer_data, it.data);
                    rx_cnt++;
                end
                in_flight = 1;
            end
            if (fall)
                chk(ecnt == ack_rise_edge + 1 + NSYNC, "req_fall_latency",
                    ecnt - ack_rise_edge, 1 + NSYNC);
            if (bus.xfer_data != prev_data)
                chk(rise, "data_stable", bus.xfer_data, prev_data);
            waiting = 0;
            foreach (exp_q[i]) if (exp_q[i].fe <= ecnt) waiting++;
            chk(bus.in_ready == (waiting == 0), "in_ready", bus.in_ready, waiting == 0);
            chk(bus.busy == (in_flight != 0 || waiting > 0), "busy", bus.busy,
                in_flight != 0 || waiting > 0);
        end
        prev_req  = bus.xfer_req;
        prev_data = bus.xfer_data;
    end

    // ---------------- producer ----------------
    bit stall = 0;

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [W-1:0] w);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && n < 500) begin
            stall = 1;
            @(negedge in_clk);
            n++;
        end
        chk(bus.in_ready, "accept_timeout", bus.in_ready, 1);
        if (bus.in_ready) exp_q.push_back('{data: w, fe: ecnt + 1});
        @(negedge in_clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        chk(bus.done, "done_timeout", bus.done, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && in_flight == 0 && !bus.busy && !bus.xfer_req &&
                 !bus.xfer_ack) && n < 3000) begin
            @(negedge in_clk);
            n++;
        end
        chk(n < 3000, "drain_timeout", n, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d0, r0, x0, fc, n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        chk(bus.xfer_req == 0, "rst_req", bus.xfer_req, 0);
        chk(bus.xfer_data == 0, "rst_data", bus.xfer_data, 0);
        chk(bus.busy == 0, "rst_busy", bus.busy, 0);
        chk(bus.in_ready == 1, "rst_ready", bus.in_ready, 1);
        chk(bus.done == 0, "rst_done", bus.done, 0);
        repeat (3) @(negedge in_clk);
        #2 reset_n = 1'b1;
        resp_force = 0;
        repeat (3) @(negedge in_clk);

        // single word
        d0 = done_cnt;
        send(32'hA5A50001);
        chk(bus.xfer_req == 1, "single_req", bus.xfer_req, 1);
        chk(bus.xfer_data == 32'hA5A50001, "single_data", bus.xfer_data, 32'hA5A50001);
        wait_done();
        @(negedge in_clk);
        chk(bus.busy == 0, "single_busy_after", bus.busy, 0);
        chk(bus.done == 0, "single_done_pulse", bus.done, 0);
        chk(done_cnt - d0 == 1, "single_done_cnt", done_cnt - d0, 1);
        wait_idle();

        // back-to-back through the pending buffer
        d0 = done_cnt; r0 = relaunch_cnt; stall = 0;
        send(32'h1); send(32'h2); send(32'h3);
        wait_idle();
        chk(stall, "b2b_stall_seen", stall, 1);
        chk(done_cnt - d0 == 3, "b2b_done_cnt", done_cnt - d0, 3);
        chk(relaunch_cnt - r0 == 2, "b2b_relaunch", relaunch_cnt - r0, 2);

        // accept on the very edge RELEASE completes
        r0 = relaunch_cnt; fc = ack_fall_cnt;
        send(32'h44);
        n = 0;
        while (ack_fall_cnt == fc && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        while (ecnt < ack_fall_edge + NSYNC) @(negedge in_clk);
        send(32'h55);
        chk(bus.done == 1, "simul_done", bus.done, 1);
        chk(bus.xfer_req == 1, "simul_req", bus.xfer_req, 1);
        chk(bus.xfer_data == 32'h55, "simul_data", bus.xfer_data, 32'h55);
        wait_idle();
        chk(relaunch_cnt - r0 == 1, "simul_relaunch", relaunch_cnt - r0, 1);

        // ack stuck high across reset
        resp_force = 1; force_val = 1'b1;
        repeat (2) @(negedge in_clk);
        #2 reset_n = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge in_clk);
        #2 reset_n = 1'b1;
        repeat (NSYNC + 3) @(negedge in_clk);
        send(32'h77);
        chk(bus.in_ready == 0, "stuck_ready", bus.in_ready, 0);
        repeat (5) begin
            chk(bus.xfer_req == 0, "stuck_no_req", bus.xfer_req, 0);
            @(negedge in_clk);
        end
        force_val = 1'b0;
        @(negedge in_clk);
        n = 0;
        while (!bus.xfer_req && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        chk(ecnt == ack_fall_edge + 1 + NSYNC, "stuck_launch_latency",
            ecnt - ack_fall_edge, 1 + NSYNC);
        chk(bus.xfer_data == 32'h77, "stuck_data", bus.xfer_data, 32'h77);
        resp_force = 0;
        wait_idle();

        // reset while REQ is up and pend holds a word
        d0 = done_cnt;
        send(32'h11);
        send(32'h99);
        #2 reset_n = 1'b0;
        #1;
        chk(bus.xfer_req == 0, "midrst_req", bus.xfer_req, 0);
        chk(bus.busy == 0, "midrst_busy", bus.busy, 0);
        chk(bus.in_ready == 1, "midrst_ready", bus.in_ready, 1);
        exp_q.delete();
        repeat (3) @(negedge in_clk);
        #2 reset_n = 1'b1;
        repeat (10) @(negedge in_clk);
        chk(bus.xfer_req == 0, "midrst_no_relaunch", bus.xfer_req, 0);
        chk(done_cnt == d0, "midrst_no_done", done_cnt - d0, 0);

        // random delays and producer gaps
        dmin = 0; dmax = 10;
        d0 = done_cnt; x0 = rx_cnt;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge in_clk);
            send($urandom);
        end
        wait_idle();
        chk(rx_cnt - x0 == 1000, "rand_rx_cnt", rx_cnt - x0, 1000);
        chk(done_cnt - d0 == 1000, "rand_done_cnt", done_cnt - d0, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
